// File: rtl/irq_timer_pkg.sv
// Register map, CTRL field layout, MODE codes and FSM state encodings for irq_timer.
package irq_timer_pkg;

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrPreset = 2'd1;
   localparam logic [1:0] AddrCount  = 2'd2;
   localparam logic [1:0] AddrRsvd   = 2'd3;

   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlModeLsb = 1;
   localparam int unsigned CtrlImBit   = 3;
   localparam int unsigned CtrlWidth   = 4;

   localparam logic [1:0] ModeOneShot  = 2'd0;
   localparam logic [1:0] ModePeriodic = 2'd1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StCnt  = 2'd2;
   localparam logic [1:0] StInt  = 2'd3;

   // Packed MSB-first, so this matches CTRL[3:0] bit for bit.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

endpackage

// File: rtl/irq_timer.sv
// Memory-mapped programmable down-counter raising a masked, registered interrupt on expiry.
// One-shot and periodic modes; bus writes override FSM updates to the same register.
module irq_timer
   import irq_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   ctrl_t            ctrl_q, ctrl_d;
   logic [WIDTH-1:0] preset_q, preset_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic             flag_q, flag_d;
   logic             wr_ctrl, wr_preset;

   assign wr_ctrl   = we && (addr == AddrCtrl);
   assign wr_preset = we && (addr == AddrPreset);

   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      state_d  = state_q;
      flag_d   = flag_q;

      if (wr_ctrl || wr_preset) begin
         flag_d = 1'b0;
      end

      // FSM set of the flag is applied after the bus clear so it wins.
      case (state_q)
         StIdle: begin
            if (ctrl_q.en) state_d = StLoad;
         end
         StLoad: begin
            count_d = preset_q;
            state_d = StCnt;
         end
         StCnt: begin
            if (!ctrl_q.en) begin
               state_d = StIdle;
            end else if (count_q <= WIDTH'(1)) begin
               count_d = '0;
               flag_d  = 1'b1;
               state_d = StInt;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
         StInt: begin
            if (ctrl_q.mode == ModePeriodic) begin
               flag_d  = 1'b0;
               state_d = StLoad;
            end else begin
               ctrl_d.en = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (wr_ctrl) begin
         ctrl_d = ctrl_t'(wdata[CtrlWidth-1:0]);
      end
      if (wr_preset) begin
         preset_d = wdata[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         state_q  <= StIdle;
         flag_q   <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         state_q  <= state_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         AddrCtrl:   rdata = {{(32 - CtrlWidth){1'b0}}, ctrl_q};
         AddrPreset: rdata = 32'(preset_q);
         AddrCount:  rdata = 32'(count_q);
         default:    rdata = '0;
      endcase
   end

   assign irq = flag_q & ctrl_q.im;

endmodule
